// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_monitor
// Purpose  : Passive checker for a two-direction traffic-light bus. Tracks the
//            colour and dwell time of each direction, and raises sticky flags
//            for these faults:
//              - non-one-hot patterns
//              - illegal colour transitions
//              - dwell violations
//              - both directions showing non-red at once
//            Counts completed R->G cycles of direction A.
// Ports    : i_clk          - system clock, rising edge
//            i_rst_n        - asynchronous active-low reset
//            i_light[5:0]   - [5:3] direction A {R,Y,G}, [2:0] direction B {R,Y,G}
//            i_clr          - synchronous clear of the four sticky error flags
//            o_valid        - both directions have been primed by a legal sample
//            o_err_onehot   - sticky: non-one-hot pattern seen (000 included)
//            o_err_seq      - sticky: illegal colour transition
//            o_err_timing   - sticky: dwell rule violated
//            o_err_conflict - sticky: both directions non-red in one sample
//            o_any_err      - OR of the four sticky flags
//            o_cycle_cnt    - count of legal A RED->GRN transitions (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_monitor #(
    parameter int GRN_MIN = 4,
    parameter int GRN_MAX = 16,
    parameter int YEL_CYC = 2,
    parameter int CNT_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [5:0]       i_light,
    input  logic             i_clr,
    output logic             o_valid,
    output logic             o_err_onehot,
    output logic             o_err_seq,
    output logic             o_err_timing,
    output logic             o_err_conflict,
    output logic             o_any_err,
    output logic [CNT_W-1:0] o_cycle_cnt
);

    // Colour encoding of the tracked per-direction state.
    localparam logic [1:0]       c_red     = 2'd0;
    localparam logic [1:0]       c_yel     = 2'd1;
    localparam logic [1:0]       c_grn     = 2'd2;
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_grn_min = CNT_W'(GRN_MIN);
    localparam logic [CNT_W-1:0] c_grn_lim = CNT_W'(GRN_MAX + 1);
    localparam logic [CNT_W-1:0] c_yel_cyc = CNT_W'(YEL_CYC);

    // Index 0 is direction A, index 1 is direction B.
    logic [1:0]       r_col    [2];
    logic [CNT_W-1:0] r_dwell  [2];
    logic [1:0]       r_primed;
    logic             r_valid;
    logic             r_err_onehot;
    logic             r_err_seq;
    logic             r_err_timing;
    logic             r_err_conflict;
    logic [CNT_W-1:0] r_cycle_cnt;

    logic [2:0]       w_pat      [2];
    logic [1:0]       w_col_in   [2];
    logic [1:0]       w_pat_ok;
    logic [1:0]       w_col_nxt  [2];
    logic [CNT_W-1:0] w_dwell_nxt[2];
    logic [CNT_W-1:0] w_dwell_inc[2];
    logic [1:0]       w_primed_nxt;
    logic [1:0]       w_oh_err;
    logic [1:0]       w_seq_err;
    logic [1:0]       w_tim_err;
    logic             w_conflict;
    logic             w_a_cycle;

    assign w_pat[0] = i_light[5:3];
    assign w_pat[1] = i_light[2:0];

    always_comb begin
        w_pat_ok     = '0;
        w_primed_nxt = r_primed;
        w_oh_err     = '0;
        w_seq_err    = '0;
        w_tim_err    = '0;
        w_a_cycle    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            w_col_in[d]    = c_red;
            w_col_nxt[d]   = r_col[d];
            w_dwell_nxt[d] = r_dwell[d];
            w_dwell_inc[d] = (r_dwell[d] == c_cnt_max) ? r_dwell[d] : r_dwell[d] + c_one;

            case (w_pat[d])
                3'b100:  begin w_col_in[d] = c_red; w_pat_ok[d] = 1'b1; end
                3'b010:  begin w_col_in[d] = c_yel; w_pat_ok[d] = 1'b1; end
                3'b001:  begin w_col_in[d] = c_grn; w_pat_ok[d] = 1'b1; end
                default: begin w_col_in[d] = c_red; w_pat_ok[d] = 1'b0; end
            endcase

            if (!w_pat_ok[d]) begin
                // Invalid pattern: state and dwell are frozen, nothing else checked.
                w_oh_err[d] = 1'b1;
            end else if (!r_primed[d]) begin
                // First legal sample after reset only establishes the colour.
                w_primed_nxt[d] = 1'b1;
                w_col_nxt[d]    = w_col_in[d];
                w_dwell_nxt[d]  = c_one;
            end else if (w_col_in[d] == r_col[d]) begin
                w_dwell_nxt[d] = w_dwell_inc[d];
                // Fire only on the step into GRN_MAX+1; the saturation guard
                // keeps a parked counter from re-triggering within one phase.
                if (r_col[d] == c_grn && w_dwell_inc[d] == c_grn_lim &&
                    r_dwell[d] != c_cnt_max) begin
                    w_tim_err[d] = 1'b1;
                end
            end else begin
                if (!((r_col[d] == c_red && w_col_in[d] == c_grn) ||
                      (r_col[d] == c_grn && w_col_in[d] == c_yel) ||
                      (r_col[d] == c_yel && w_col_in[d] == c_red))) begin
                    w_seq_err[d] = 1'b1;
                end
                if (r_col[d] == c_grn && r_dwell[d] < c_grn_min) begin
                    w_tim_err[d] = 1'b1;
                end
                if (r_col[d] == c_yel && r_dwell[d] != c_yel_cyc) begin
                    w_tim_err[d] = 1'b1;
                end
                if (d == 0 && r_col[d] == c_red && w_col_in[d] == c_grn) begin
                    w_a_cycle = 1'b1;
                end
                w_col_nxt[d]   = w_col_in[d];
                w_dwell_nxt[d] = c_one;
            end
        end

        w_conflict = w_pat_ok[0] && w_pat_ok[1] &&
                     (w_col_in[0] != c_red) && (w_col_in[1] != c_red);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int d = 0; d < 2; d++) begin
                r_col[d]   <= c_red;
                r_dwell[d] <= '0;
            end
            r_primed       <= '0;
            r_valid        <= 1'b0;
            r_err_onehot   <= 1'b0;
            r_err_seq      <= 1'b0;
            r_err_timing   <= 1'b0;
            r_err_conflict <= 1'b0;
            r_cycle_cnt    <= '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                r_col[d]   <= w_col_nxt[d];
                r_dwell[d] <= w_dwell_nxt[d];
            end
            r_primed <= w_primed_nxt;
            r_valid  <= r_valid | (&r_primed);
            // A new error on the clearing edge wins over the clear.
            r_err_onehot   <= (r_err_onehot   & ~i_clr) | (|w_oh_err);
            r_err_seq      <= (r_err_seq      & ~i_clr) | (|w_seq_err);
            r_err_timing   <= (r_err_timing   & ~i_clr) | (|w_tim_err);
            r_err_conflict <= (r_err_conflict & ~i_clr) | w_conflict;
            if (w_a_cycle) begin
                r_cycle_cnt <= r_cycle_cnt + c_one;
            end
        end
    end

    assign o_valid        = r_valid;
    assign o_err_onehot   = r_err_onehot;
    assign o_err_seq      = r_err_seq;
    assign o_err_timing   = r_err_timing;
    assign o_err_conflict = r_err_conflict;
    assign o_any_err      = r_err_onehot | r_err_seq | r_err_timing | r_err_conflict;
    assign o_cycle_cnt    = r_cycle_cnt;

endmodule
`default_nettype wire

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the receiving end of the traffic-light controller's 6-bit `o_light` bus.
- Samples the light vector every clock and checks three things:
  - per-direction one-hot encoding;
  - legal colour sequencing and dwell timing;
  - cross-direction conflicts.
- Reports problems on sticky error flags and counts completed cycles of direction A.
- Sits beside the controller in system benches and on-chip as a safety watchdog.

Parameters:
- GRN_MIN, 4, minimum legal green dwell in cycles
- GRN_MAX, 16, maximum legal green dwell in cycles; exceeding it is a timing error
- YEL_CYC, 2, exact required yellow dwell in cycles
- CNT_W, 8, width of the dwell counters and the cycle counter

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_light  input  6  light vector, mapped as:
  - [5:3] = direction A {R,Y,G}
  - [2:0] = direction B {R,Y,G}
- i_clr  input  1  synchronous clear of all sticky error flags
- o_valid  output  1  high once at least one legal sample per direction has been captured
- o_err_onehot  output  1  sticky: a direction showed a non-one-hot pattern (000 included)
- o_err_seq  output  1  sticky: illegal colour transition
- o_err_timing  output  1  sticky: dwell rule violated
- o_err_conflict  output  1  sticky: both directions non-red in the same sample
- o_any_err  output  1  OR of the four sticky flags
- o_cycle_cnt  output  CNT_W  count of A transitions R->G, wraps modulo 2^CNT_W

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - all outputs are 0;
  - tracked colours and dwell counters are cleared;
  - primed bits are cleared.
  - Reset asserted mid-operation aborts all checks immediately.
  - After release, the first legal sample of each direction only primes it; no transition or timing check is made on that sample.
- Sampling and latency:
  - Every rising edge evaluates i_light against the registered per-direction state.
  - Flags rise on the same edge the offending sample is captured and are visible one cycle after i_light shows it.
- State per direction: a colour register with values RED, YEL, GRN, plus a primed bit.
  - Legal transitions: RED->GRN, GRN->YEL, YEL->RED.
  - Holding the same colour is always legal.
  - Any other change sets o_err_seq; the tracked colour still updates to the new colour.
- One-hot check:
  - Any direction pattern not in {100, 010, 001} sets o_err_onehot.
  - That direction's colour and dwell are held; no other check is made for it on that sample.
- Dwell counter per direction:
  - Set to 1 on entry to a colour, incremented each cycle the colour is held.
  - Saturates at 2^CNT_W-1.
- On leaving GRN:
  - dwell < GRN_MIN sets o_err_timing.
- While in GRN:
  - the counter reaching GRN_MAX+1 sets o_err_timing, once per green phase.
- On leaving YEL:
  - dwell != YEL_CYC sets o_err_timing.
- Conflict:
  - A sample where both directions are valid one-hot and neither is RED sets o_err_conflict.
  - Invalid patterns do not count toward conflict.
- Cycle counter:
  - o_cycle_cnt increments on each legal A transition RED->GRN with A primed.
  - Wraps 2^CNT_W-1 -> 0.
- i_clr:
  - clears the four sticky flags at the next edge;
  - does not affect counters, colour state or o_valid.
  - If i_clr and a new error occur on the same edge, the new error wins and its flag is 1.
- o_valid:
  - goes high the edge after both directions are primed;
  - stays high until reset.

Test Plan:
- Reset then legal sequence, A: G 4, Y 2, R 6 cycles; B complementary: 100 while A non-red, then B G 4, Y 2 -> no flags; o_cycle_cnt 0->1 on A's second R->G; o_valid high from cycle 2.
- A goes G->R directly (i_light 001100 -> 100100) -> o_err_seq=1 one cycle later; o_any_err=1; stays set until i_clr pulse; then 0.
- A yellow held 3 cycles with YEL_CYC=2 -> o_err_timing=1 at the Y->R edge. A green held 17 cycles -> o_err_timing at the 17th green sample.
- i_light=001001 (both green) -> o_err_conflict=1. i_light=000100 -> o_err_onehot=1, A state and dwell unchanged, no conflict.
- i_clr asserted on the same edge as a seq error -> o_err_seq remains 1. Assert i_rst_n low mid-green -> all outputs 0 immediately. First post-reset sample in YEL -> no seq error.
- With CNT_W=2, run 4 legal A cycles -> o_cycle_cnt sequence 1,2,3,0.
